// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the ID stage: one saturating counter per R/F/M register,
// gating issue on RAW hazards and on a full destination counter.
module reg_scoreboard #(
    parameter int CNT_W   = 2,
    parameter bit TRACK_M = 1'b1,
    parameter int INF_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             ex_ready,
    input  logic [1:0]       rs1_group,
    input  logic [4:0]       rs1_index,
    input  logic [1:0]       rs2_group,
    input  logic [4:0]       rs2_index,
    input  logic [1:0]       rs3_group,
    input  logic [4:0]       rs3_index,
    input  logic [1:0]       rd_group,
    input  logic [4:0]       rd_index,
    input  logic             wb_valid,
    input  logic [1:0]       wb_group,
    input  logic [4:0]       wb_index,
    output logic             issue_ready,
    output logic             issue_fire,
    output logic [2:0]       conflict,
    output logic             busy,
    output logic [INF_W-1:0] inflight,
    output logic             err_underflow
);

    localparam logic [1:0]       REG_GROUP_R       = 2'd0;
    localparam logic [1:0]       REG_GROUP_F       = 2'd1;
    localparam logic [1:0]       REG_GROUP_M       = 2'd2;
    localparam logic [1:0]       REG_GROUP_INVALID = 2'd3;
    localparam int               NREG              = 96;
    localparam logic [CNT_W-1:0] CNT_MAX           = '1;

    function automatic logic counted(input logic [1:0] g, input logic [4:0] i);
        counted = (g != REG_GROUP_INVALID) && !(g == REG_GROUP_R && i == 5'd0)
                  && (g != REG_GROUP_M || TRACK_M);
    endfunction

    // {group,index} is group*32+index; invalid group maps to 0 and is masked by counted()
    function automatic logic [6:0] slot(input logic [1:0] g, input logic [4:0] i);
        slot = (g == REG_GROUP_INVALID) ? 7'd0 : {g, i};
    endfunction

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [6:0] rs1_slot, rs2_slot, rs3_slot, rd_slot, wb_slot;
    logic       rd_cnt, rd_full, wb_cnt, wb_zero, inc, dec;

    assign rs1_slot = slot(rs1_group, rs1_index);
    assign rs2_slot = slot(rs2_group, rs2_index);
    assign rs3_slot = slot(rs3_group, rs3_index);
    assign rd_slot  = slot(rd_group, rd_index);
    assign wb_slot  = slot(wb_group, wb_index);

    always_comb begin
        conflict[0] = counted(rs1_group, rs1_index) && (cnt_q[rs1_slot] != '0);
        conflict[1] = counted(rs2_group, rs2_index) && (cnt_q[rs2_slot] != '0);
        conflict[2] = counted(rs3_group, rs3_index) && (cnt_q[rs3_slot] != '0);

        rd_cnt      = counted(rd_group, rd_index);
        rd_full     = rd_cnt && (cnt_q[rd_slot] == CNT_MAX);
        issue_ready = ex_ready && !(|conflict) && !rd_full && !flush;
        issue_fire  = id_valid && issue_ready;

        wb_cnt  = wb_valid && counted(wb_group, wb_index);
        wb_zero = (cnt_q[wb_slot] == '0);
        inc     = issue_fire && rd_cnt;
        dec     = wb_cnt && !wb_zero && !flush;
        err_d   = err_q || (wb_cnt && wb_zero && !flush);

        cnt_d = cnt_q;
        if (flush) begin
            for (int k = 0; k < NREG; k++) cnt_d[k] = '0;
            inflight_d = '0;
        end else begin
            // decrement applied on top of the increment so a same-register pair nets to zero
            if (inc) cnt_d[rd_slot] = cnt_q[rd_slot] + CNT_W'(1);
            if (dec) cnt_d[wb_slot] = cnt_d[wb_slot] - CNT_W'(1);
            inflight_d = inflight_q + INF_W'(inc) - INF_W'(dec);
        end
        busy_d = (inflight_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NREG; k++) cnt_q[k] <= '0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign inflight      = inflight_q;
    assign busy          = busy_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic
// compared against an array-based reference model of the pending-write rules.
module tb_reg_scoreboard;

    localparam logic [1:0] GR = 2'd0, GF = 2'd1, GI = 2'd3;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, id_valid, ex_ready, wb_valid;
    logic [1:0] rs1_group, rs2_group, rs3_group, rd_group, wb_group;
    logic [4:0] rs1_index, rs2_index, rs3_index, rd_index, wb_index;
    logic       issue_ready, issue_fire, busy, err_underflow;
    logic [2:0] conflict;
    logic [8:0] inflight;

    int checks = 0, failures = 0;
    int mc[96];
    int minf;
    bit merr;

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .ex_ready(ex_ready),
        .rs1_group(rs1_group), .rs1_index(rs1_index), .rs2_group(rs2_group), .rs2_index(rs2_index),
        .rs3_group(rs3_group), .rs3_index(rs3_index), .rd_group(rd_group), .rd_index(rd_index),
        .wb_valid(wb_valid), .wb_group(wb_group), .wb_index(wb_index),
        .issue_ready(issue_ready), .issue_fire(issue_fire), .conflict(conflict),
        .busy(busy), .inflight(inflight), .err_underflow(err_underflow)
    );

    function automatic bit m_counted(input logic [1:0] g, input logic [4:0] i);
        return (g != GI) && !(g == GR && i == 5'd0);
    endfunction

    function automatic int m_idx(input logic [1:0] g, input logic [4:0] i);
        return int'(g) * 32 + int'(i);
    endfunction

    function automatic int m_pend(input logic [1:0] g, input logic [4:0] i);
        return m_counted(g, i) ? mc[m_idx(g, i)] : 0;
    endfunction

    function automatic logic [2:0] m_conflict();
        logic [2:0] c;
        c[0] = m_pend(rs1_group, rs1_index) != 0;
        c[1] = m_pend(rs2_group, rs2_index) != 0;
        c[2] = m_pend(rs3_group, rs3_index) != 0;
        return c;
    endfunction

    function automatic bit m_ready();
        bit full;
        full = m_counted(rd_group, rd_index) && m_pend(rd_group, rd_index) == CMAX;
        return ex_ready && m_conflict() == 3'b000 && !full && !flush;
    endfunction

    task automatic m_reset();
        foreach (mc[k]) mc[k] = 0;
        minf = 0;
        merr = 0;
    endtask

    // Model update for the upcoming edge, evaluated from the inputs held during the cycle
    task automatic m_clock();
        bit fire, wb_hit, wb_was_zero;
        if (flush) begin
            foreach (mc[k]) mc[k] = 0;
        end else begin
            fire        = id_valid && m_ready();
            wb_hit      = wb_valid && m_counted(wb_group, wb_index);
            wb_was_zero = m_pend(wb_group, wb_index) == 0;
            if (fire && m_counted(rd_group, rd_index)) mc[m_idx(rd_group, rd_index)]++;
            if (wb_hit) begin
                if (wb_was_zero) merr = 1;
                else mc[m_idx(wb_group, wb_index)]--;
            end
        end
        minf = 0;
        foreach (mc[k]) minf += mc[k];
    endtask

    task automatic tick();
        m_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; id_valid = 0; ex_ready = 1; wb_valid = 0;
        rs1_group = GI; rs2_group = GI; rs3_group = GI; rd_group = GI; wb_group = GI;
        rs1_index = 0; rs2_index = 0; rs3_index = 0; rd_index = 0; wb_index = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        m_reset();
        for (int n = 0; n < 4; n++) begin
            flush = 1'($urandom); id_valid = 1'($urandom); ex_ready = 1'($urandom);
            wb_valid = 1'($urandom); rd_group = 2'($urandom); rd_index = 5'($urandom);
            wb_group = 2'($urandom); wb_index = 5'($urandom);
            @(negedge clk);
            checks++;
            if (inflight !== 9'd0 || busy !== 1'b0 || err_underflow !== 1'b0) begin
                failures++;
                $display("FAIL reset_state: inflight=%0d busy=%b err=%b expected 0/0/0",
                         inflight, busy, err_underflow);
            end
        end
        idle();
        rst = 1;
        @(posedge clk); #1;
        id_valid = 1;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: issue_ready=%b expected 1", issue_ready);
        end
        tick();
    endtask

    task automatic test_raw();
        idle(); id_valid = 1; rd_group = GR; rd_index = 5;
        @(negedge clk);
        checks++;
        if (issue_fire !== 1'b1) begin
            failures++; $display("FAIL raw_issue: issue_fire=%b expected 1", issue_fire);
        end
        tick();
        rd_group = GI; rs1_group = GR; rs1_index = 5;
        @(negedge clk);
        checks++;
        if (conflict !== 3'b001 || issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL raw_conflict: conflict=%b ready=%b expected 001/0", conflict, issue_ready);
        end
        tick();
        wb_valid = 1; wb_group = GR; wb_index = 5;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++; $display("FAIL raw_no_bypass: issue_ready=%b expected 0", issue_ready);
        end
        tick();
        wb_valid = 0;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1 || conflict !== 3'b000) begin
            failures++;
            $display("FAIL raw_release: ready=%b conflict=%b expected 1/000", issue_ready, conflict);
        end
        tick();
        checks++;
        if (inflight !== 9'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL raw_drained: inflight=%0d busy=%b expected 0/0", inflight, busy);
        end
    endtask

    task automatic test_x0_invalid();
        idle(); id_valid = 1;
        for (int n = 0; n < 6; n++) begin
            rd_group = (n < 3) ? GR : GI;
            rd_index = 0;
            tick();
        end
        checks++;
        if (inflight !== 9'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL x0_not_counted: inflight=%0d busy=%b expected 0/0", inflight, busy);
        end
        rd_group = GF; rd_index = 0;
        tick();
        rd_group = GI; rs2_group = GR; rs2_index = 0; rs1_group = GF; rs1_index = 0;
        @(negedge clk);
        checks++;
        if (conflict !== 3'b001) begin
            failures++; $display("FAIL f0_conflict: conflict=%b expected 001", conflict);
        end
        id_valid = 0; wb_valid = 1; wb_group = GF; wb_index = 0;
        tick();
        idle();
        tick();
    endtask

    task automatic test_saturation();
        idle(); id_valid = 1; rd_group = GF; rd_index = 7;
        for (int n = 0; n < 3; n++) tick();
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b0 || inflight !== 9'd3) begin
            failures++;
            $display("FAIL sat_full: ready=%b inflight=%0d expected 0/3", issue_ready, inflight);
        end
        wb_valid = 1; wb_group = GF; wb_index = 7;
        tick();
        wb_valid = 0;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1 || inflight !== 9'd2) begin
            failures++;
            $display("FAIL sat_release: ready=%b inflight=%0d expected 1/2", issue_ready, inflight);
        end
        tick();
        id_valid = 0; wb_valid = 1;
        for (int n = 0; n < 3; n++) tick();
        checks++;
        if (inflight !== 9'd0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL sat_drain: inflight=%0d err=%b expected 0/0", inflight, err_underflow);
        end
        idle();
    endtask

    task automatic test_simultaneous();
        idle(); id_valid = 1; rd_group = GR; rd_index = 3;
        tick();
        wb_valid = 1; wb_group = GR; wb_index = 3;
        tick();
        checks++;
        if (inflight !== 9'd1 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL same_reg_net: inflight=%0d err=%b expected 1/0", inflight, err_underflow);
        end
        wb_index = 4;
        tick();
        id_valid = 0; wb_valid = 0;
        tick(); tick();
        checks++;
        if (err_underflow !== 1'b1 || inflight !== 9'd2) begin
            failures++;
            $display("FAIL underflow_sticky: err=%b inflight=%0d expected 1/2", err_underflow, inflight);
        end
        wb_valid = 1; wb_index = 3;
        tick(); tick();
        idle();
    endtask

    task automatic test_flush();
        idle(); id_valid = 1; rd_group = GR;
        for (int n = 1; n <= 5; n++) begin
            rd_index = 5'(n);
            tick();
        end
        checks++;
        if (inflight !== 9'd5 || busy !== 1'b1) begin
            failures++; $display("FAIL flush_setup: inflight=%0d busy=%b expected 5/1", inflight, busy);
        end
        flush = 1; rd_index = 6;
        @(negedge clk);
        checks++;
        if (issue_fire !== 1'b0) begin
            failures++; $display("FAIL flush_fire: issue_fire=%b expected 0", issue_fire);
        end
        tick();
        checks++;
        if (inflight !== 9'd0 || busy !== 1'b0 || err_underflow !== merr) begin
            failures++;
            $display("FAIL flush_clear: inflight=%0d busy=%b err=%b expected 0/0/%b",
                     inflight, busy, err_underflow, merr);
        end
        idle();
    endtask

    task automatic test_random();
        idle();
        rst = 0; m_reset();
        @(negedge clk);
        rst = 1;
        tick();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                idle(); rst = 0; m_reset();
                @(negedge clk);
                checks++;
                if (inflight !== 9'd0 || busy !== 1'b0 || err_underflow !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_async_reset: inflight=%0d busy=%b err=%b", inflight, busy, err_underflow);
                end
                rst = 1;
                tick();
            end
            rs1_group = 2'($urandom_range(0, 3)); rs1_index = 5'($urandom_range(0, 3));
            rs2_group = 2'($urandom_range(0, 3)); rs2_index = 5'($urandom_range(0, 3));
            rs3_group = 2'($urandom_range(0, 3)); rs3_index = 5'($urandom_range(0, 3));
            rd_group  = 2'($urandom_range(0, 3)); rd_index  = 5'($urandom_range(0, 3));
            wb_group  = 2'($urandom_range(0, 3)); wb_index  = 5'($urandom_range(0, 3));
            id_valid  = $urandom_range(0, 3) != 0;
            ex_ready  = $urandom_range(0, 7) != 0;
            wb_valid  = $urandom_range(0, 2) == 0;
            flush     = $urandom_range(0, 24) == 0;
            @(negedge clk);
            checks++;
            if (conflict !== m_conflict() || issue_ready !== m_ready()
                || issue_fire !== (id_valid && m_ready())) begin
                failures++;
                $display("FAIL rand_comb[%0d]: conflict=%b ready=%b fire=%b expected %b/%b/%b", n,
                         conflict, issue_ready, issue_fire, m_conflict(), m_ready(), id_valid && m_ready());
            end
            tick();
            checks++;
            if (inflight !== 9'(minf) || busy !== (minf != 0) || err_underflow !== merr) begin
                failures++;
                $display("FAIL rand_state[%0d]: inflight=%0d busy=%b err=%b expected %0d/%b/%b", n,
                         inflight, busy, err_underflow, minf, minf != 0, merr);
            end
        end
    endtask

    initial begin
        idle();
        rst = 0;
        m_reset();
        test_reset();
        test_raw();
        test_x0_invalid();
        test_saturation();
        test_simultaneous();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
